agc_pulse_gen: RTL and testbench
================================

// Module: agc_pulse_gen
// PURPOSE
//  Synthetic alpha/gamma pulse source for bench calibration of the peak counter. Drives the DAC channels:
//  A = alpha, B = gamma. Software pushes pulse descriptors {type, amp, width, gap} over the sys bus into a
//  descriptor FIFO. A playback FSM turns each descriptor into a rectangular pulse followed by a zero gap.
//  The counter reports width as (cycles-1) and the peak as amp, so a DAC->ADC loopback closes the calibration loop.
// PARAMETERS
//  FIFO_DEPTH  16  descriptor FIFO entries; power of 2, 2..256
//  DW          14  DAC sample width; signed two's complement
// PORTS
//  clk_i      in   1   system clock, one clock domain
//  rstn_i     in   1   reset; asynchronous, active-low
//  dat_a_o    out  14  chA DAC sample (alpha), registered
//  dat_b_o    out  14  chB DAC sample (gamma), registered
//  busy_o     out  1   1 while FSM not in IDLE
//  sys_addr   in   32  bus address; only [19:0] decoded
//  sys_wdata  in   32  bus write data
//  sys_sel    in   4   byte select; ignored, all writes are full-word
//  sys_wen    in   1   bus write strobe, 1 cycle
//  sys_ren    in   1   bus read strobe, 1 cycle
//  sys_rdata  out  32  read data, registered
//  sys_err    out  1   constant 0
//  sys_ack    out  1   registered (sys_wen|sys_ren), 1 cycle later
// BEHAVIOUR
//  Reset values: dat_a_o = dat_b_o = 0, busy_o = 0, sys_ack = sys_err = 0, sys_rdata = 0. FIFO empty, counters 0,
//   CTRL = 0, staged descriptor = 0, FSM in IDLE.
//  Register map:
//   0x00 CTRL  RW  [0] enable; [1] flush, write-1 self-clearing, reads 0.
//   0x04 DESC0 RW  [13:0] amp (signed); [17:16] type: 0 = A only, 1 = B only, 2 = A+B coincident, 3 = reserved,
//                  treated as 0. Staged only; no push.
//   0x08 DESC1 W   [15:0] width, [31:16] gap. Each write pushes {DESC0, width, gap} into the FIFO.
//                  Reads return the last value written.
//   0x0C STAT  R   [15:0] FIFO level; [16] busy; [17] FIFO full.
//   0x10 LOST  R   pushes dropped because the FIFO was full; saturates at 2^32-1.
//   0x14 EMIT  R   descriptors completed (gap finished); wraps.
//   Other offsets: writes ignored, reads return 0; sys_ack still asserted.
//  FSM states IDLE, PULSE, GAP:
//   IDLE -> PULSE when enable=1 and FIFO non-empty. The same edge pops the head, loads wcnt=width and
//    gcnt=gap, and registers amp onto the channel(s) selected by type (unselected channel = 0).
//   PULSE: amp is held. If wcnt==0, go to GAP and drive both outputs 0; else decrement wcnt.
//    Result: the pulse lasts width+1 cycles; width=0 gives 1 cycle, width=65535 gives 65536 cycles.
//   GAP: outputs 0. If gcnt==0, EMIT++ and go to IDLE; else decrement gcnt. The gap lasts gap+1 cycles, so
//    back-to-back descriptors are separated by gap+1 zero cycles, plus 1 IDLE cycle if the FIFO is non-empty.
//  Latency: a DESC1 write at edge N makes the FIFO non-empty after N. With enable=1 and FSM in IDLE,
//   amp appears on dat_*_o after edge N+1.
//  Boundaries:
//   Push when full -> descriptor dropped, LOST++, FIFO unchanged. Push and pop on the same edge while full
//    -> both accepted, level unchanged, no loss.
//   Push when empty with the FSM idle -> no bypass; the 1-cycle latency above applies.
//   enable 1->0 mid-pulse or mid-gap -> the current descriptor completes (PULSE then GAP, EMIT++), then IDLE;
//    no further pops.
//   flush -> FIFO emptied and FSM forced to IDLE, outputs 0 on the next edge. EMIT not incremented for the
//    aborted descriptor; LOST and EMIT otherwise unchanged. Flush and push in the same cycle cannot occur
//    (different addresses).
//   rstn_i low at any time -> all state back to reset values immediately (async), including mid-pulse.
//   amp is passed through unchanged; no clipping or arithmetic on the sample path.
// STRUCTURE
//  agc_pkg: register offsets (CTRL/DESC0/DESC1/STAT/LOST/EMIT), type encodings, FSM state enum,
//   descriptor width constants (AMP_W=14, WID_W=16, GAP_W=16, TYPE_W=2).
//  Sub-module agc_desc_fifo: synchronous FIFO, width 48, depth FIFO_DEPTH, push/pop/flush, level/full/empty,
//   first-word-fall-through; pop and push in the same cycle are legal.
//  Top level: bus decode/readback, LOST/EMIT counters, playback FSM, output registers.
// TESTING
//  Single pulse: DESC0 = amp 1000, type 0; DESC1 = width 9, gap 4; CTRL = 1 -> dat_a_o = 1000 for exactly
//   10 cycles, dat_b_o = 0 throughout, then 5 zero cycles, EMIT = 1.
//  Coincident pulse: type 2, amp -2000 (0x3830), width 0 -> both channels -2000 for 1 cycle, in phase; EMIT = 1.
//  Overflow: enable=0, push 18 descriptors -> STAT level = 16, full = 1, LOST = 2. Then enable -> 16 pulses
//   emitted in push order; EMIT = 16.
//  Full push+pop: FIFO full, FSM popping; write DESC1 on the pop edge -> level stays 16, LOST unchanged.
//  Disable and flush: clear enable mid-pulse -> pulse and gap complete, then idle with queued entries
//   retained. Write flush -> level 0, outputs 0 on the next cycle.
//  Async reset mid-PULSE: rstn_i low -> outputs 0 and busy_o 0 without waiting for a clock edge; all
//   registers read back reset values.

Source files
------------

// File: rtl/agc_pkg.sv
// agc_pkg: register map, descriptor layout, type encodings and playback states
package agc_pkg;
  localparam int AMP_W  = 14;
  localparam int WID_W  = 16;
  localparam int GAP_W  = 16;
  localparam int TYPE_W = 2;
  localparam int DESC_W = TYPE_W + AMP_W + WID_W + GAP_W;
  localparam logic [19:0] REG_CTRL  = 20'h00;
  localparam logic [19:0] REG_DESC0 = 20'h04;
  localparam logic [19:0] REG_DESC1 = 20'h08;
  localparam logic [19:0] REG_STAT  = 20'h0C;
  localparam logic [19:0] REG_LOST  = 20'h10;
  localparam logic [19:0] REG_EMIT  = 20'h14;
  localparam logic [TYPE_W-1:0] TYPE_A  = 2'd0;
  localparam logic [TYPE_W-1:0] TYPE_B  = 2'd1;
  localparam logic [TYPE_W-1:0] TYPE_AB = 2'd2;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  typedef struct packed {
    logic [TYPE_W-1:0] kind;
    logic [AMP_W-1:0]  amp;
    logic [WID_W-1:0]  width;
    logic [GAP_W-1:0]  gap;
  } desc_t;
  // reserved type 3 falls back to A-only
  function automatic logic sel_a(input logic [TYPE_W-1:0] kind);
    return kind != TYPE_B;
  endfunction
  function automatic logic sel_b(input logic [TYPE_W-1:0] kind);
    return kind == TYPE_B || kind == TYPE_AB;
  endfunction
endpackage

// File: rtl/agc_desc_fifo.sv
// agc_desc_fifo: first-word-fall-through descriptor FIFO with flush; push while full is accepted only alongside a pop
module agc_desc_fifo
  import agc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = DESC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign dout    = mem[rptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
  // storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/agc_pulse_gen.sv
// agc_pulse_gen: bus-programmed alpha/gamma rectangular pulse player driving two DAC channels
module agc_pulse_gen
  import agc_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DW         = 14
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  output logic [DW-1:0] dat_a_o,
  output logic [DW-1:0] dat_b_o,
  output logic          busy_o,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic [3:0]    sys_sel,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  desc_t head;
  logic en, pop, done, push, flush, full, empty, unused;
  logic [TYPE_W-1:0] kind0;
  logic [AMP_W-1:0] amp0;
  logic [31:0] desc1, lost, emit, rd_mux;
  logic [WID_W-1:0] wcnt, wcnt_n;
  logic [GAP_W-1:0] gcnt, gcnt_n;
  logic [DW-1:0] a_n, b_n;
  logic [LW-1:0] level;
  logic [19:0] addr;
  assign addr    = sys_addr[19:0];
  assign push    = sys_wen && addr == REG_DESC1;
  assign flush   = sys_wen && addr == REG_CTRL && sys_wdata[1];
  assign busy_o  = state != IDLE;
  assign sys_err = 1'b0;
  assign unused  = ^{sys_sel, sys_addr[31:20]};
  assign rd_mux  = addr == REG_CTRL  ? {31'b0, en} :
                   addr == REG_DESC0 ? {14'b0, kind0, 2'b0, amp0} :
                   addr == REG_DESC1 ? desc1 :
                   addr == REG_STAT  ? {14'b0, full, busy_o, 16'(level)} :
                   addr == REG_LOST  ? lost :
                   addr == REG_EMIT  ? emit : 32'h0;
  agc_desc_fifo #(.DEPTH(FIFO_DEPTH), .W(DESC_W)) u_fifo (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({kind0, amp0, sys_wdata[15:0], sys_wdata[31:16]}),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );
  // bus registers, readback and the LOST/EMIT event counters
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en        <= 1'b0;
      kind0     <= '0;
      amp0      <= '0;
      desc1     <= '0;
      lost      <= '0;
      emit      <= '0;
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      if (sys_ren) sys_rdata <= rd_mux;
      if (sys_wen && addr == REG_CTRL) en <= sys_wdata[0];
      if (sys_wen && addr == REG_DESC0) begin
        amp0  <= sys_wdata[AMP_W-1:0];
        kind0 <= sys_wdata[17:16];
      end
      if (push) desc1 <= sys_wdata;
      if (push && full && !pop && lost != '1) lost <= lost + 1'b1;
      if (done) emit <= emit + 1'b1;
    end
  end
  // playback state, width/gap down-counters and registered DAC samples
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      wcnt    <= '0;
      gcnt    <= '0;
      dat_a_o <= '0;
      dat_b_o <= '0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      gcnt    <= gcnt_n;
      dat_a_o <= a_n;
      dat_b_o <= b_n;
    end
  end
  // next-state: pop and load in IDLE, hold amp for width+1, zero for gap+1; flush aborts without counting
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    gcnt_n  = gcnt;
    a_n     = dat_a_o;
    b_n     = dat_b_o;
    pop     = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (en && !empty) begin
        pop     = 1'b1;
        state_n = PULSE;
        wcnt_n  = head.width;
        gcnt_n  = head.gap;
        a_n     = sel_a(head.kind) ? DW'($signed(head.amp)) : '0;
        b_n     = sel_b(head.kind) ? DW'($signed(head.amp)) : '0;
      end
      PULSE: if (wcnt == '0) begin
        state_n = GAP;
        a_n     = '0;
        b_n     = '0;
      end else wcnt_n = wcnt - 1'b1;
      GAP: if (gcnt == '0) begin
        state_n = IDLE;
        done    = 1'b1;
      end else gcnt_n = gcnt - 1'b1;
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      a_n     = '0;
      b_n     = '0;
      pop     = 1'b0;
      done    = 1'b0;
    end
  end
endmodule

// File: tb/tb_agc_pulse_gen.sv
// tb_agc_pulse_gen: directed and randomized playback checks against a descriptor-queue waveform model
module tb_agc_pulse_gen;
  localparam logic [31:0] CTRL = 32'h00, DESC0 = 32'h04, DESC1 = 32'h08;
  localparam logic [31:0] STAT = 32'h0C, LOST = 32'h10, EMIT = 32'h14;
  typedef struct {int t; logic [13:0] amp; int w; int g;} d_t;
  logic clk = 1'b0, rstn_i = 1'b0;
  logic [13:0] dat_a_o, dat_b_o;
  logic busy_o, sys_wen = 1'b0, sys_ren = 1'b0, sys_err, sys_ack;
  logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata;
  logic [3:0] sys_sel = 4'hf;
  int total = 0, bad = 0, lost_m = 0, emit_m = 0;
  d_t mq[$];
  logic [13:0] ea[$], eb[$];
  logic eby[$];
  agc_pulse_gen dut (
    .clk_i(clk), .rstn_i(rstn_i), .dat_a_o(dat_a_o), .dat_b_o(dat_b_o), .busy_o(busy_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel), .sys_wen(sys_wen),
    .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sys_addr = a;
    sys_wdata = d;
    sys_wen = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    sys_addr = a;
    sys_ren = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0;
    chk({tag, "_ack"}, 32'(sys_ack), 32'd1);
    chk(tag, sys_rdata, exp);
  endtask
  task automatic push_desc(input int t, input logic [13:0] amp, input int w, input int g);
    wr(DESC0, {14'b0, 2'(t), 2'b0, amp});
    wr(DESC1, {16'(g), 16'(w)});
    if (mq.size() < 16) mq.push_back('{t, amp, w, g});
    else lost_m++;
  endtask
  task automatic play();
    ea.delete(); eb.delete(); eby.delete();
    ea.push_back(14'd0); eb.push_back(14'd0); eby.push_back(1'b0);
    while (mq.size() > 0) begin
      d_t d;
      d = mq.pop_front();
      for (int i = 0; i <= d.w; i++) begin
        ea.push_back(d.t == 1 ? 14'd0 : d.amp);
        eb.push_back((d.t == 1 || d.t == 2) ? d.amp : 14'd0);
        eby.push_back(1'b1);
      end
      for (int i = 0; i <= d.g; i++) begin
        ea.push_back(14'd0); eb.push_back(14'd0); eby.push_back(1'b1);
      end
      ea.push_back(14'd0); eb.push_back(14'd0); eby.push_back(1'b0);
      emit_m++;
    end
    wr(CTRL, 32'd1);
    foreach (ea[i]) begin
      chk("dat_a", 32'(dat_a_o), 32'(ea[i]));
      chk("dat_b", 32'(dat_b_o), 32'(eb[i]));
      chk("busy", 32'(busy_o), 32'(eby[i]));
      @(negedge clk);
    end
    wr(CTRL, 32'd0);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_dat_a", 32'(dat_a_o), 0);
    chk("rst_dat_b", 32'(dat_b_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ack", 32'(sys_ack), 0);
    chk("rst_rdata", sys_rdata, 0);
    chk("rst_err", 32'(sys_err), 0);
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    rd_chk("ctrl0", CTRL, 0);
    rd_chk("desc0_0", DESC0, 0);
    rd_chk("desc1_0", DESC1, 0);
    rd_chk("stat0", STAT, 0);
    rd_chk("lost0", LOST, 0);
    rd_chk("emit0", EMIT, 0);
    push_desc(0, 14'd1000, 9, 4);
    rd_chk("desc0_rb", DESC0, 32'd1000);
    rd_chk("desc1_rb", DESC1, 32'h0004_0009);
    play();
    rd_chk("emit_single", EMIT, 1);
    push_desc(2, 14'h3830, 0, 2);
    rd_chk("desc0_coinc", DESC0, 32'h0002_3830);
    play();
    rd_chk("emit_coinc", EMIT, 2);
    repeat (4) begin
      int k;
      k = $urandom_range(1, 6);
      repeat (k) push_desc($urandom_range(0, 3), 14'($urandom), $urandom_range(0, 7), $urandom_range(0, 5));
      play();
    end
    rd_chk("emit_rand", EMIT, emit_m);
    rd_chk("lost_rand", LOST, lost_m);
    wr(32'h18, 32'h5);
    rd_chk("bad_off", 32'h18, 0);
    repeat (18) push_desc($urandom_range(0, 3), 14'($urandom), $urandom_range(0, 7), $urandom_range(0, 5));
    rd_chk("stat_full", STAT, 32'h0002_0010);
    rd_chk("lost_ovf", LOST, lost_m);
    play();
    rd_chk("emit_ovf", EMIT, emit_m);
    rd_chk("stat_drained", STAT, 0);
    wr(DESC0, 32'd777);
    repeat (16) wr(DESC1, 32'h0000_0003);
    wr(CTRL, 32'd1);
    wr(DESC1, 32'h0000_0003);
    chk("pp_dat_a", 32'(dat_a_o), 777);
    rd_chk("pp_stat", STAT, 32'h0003_0010);
    rd_chk("pp_lost", LOST, lost_m);
    wr(CTRL, 32'd0);
    chk("dis_hold", 32'(dat_a_o), 777);
    begin
      int n;
      n = 0;
      while (busy_o && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("dis_idle", 32'(busy_o), 0);
    chk("dis_dat", 32'(dat_a_o), 0);
    emit_m++;
    rd_chk("dis_stat", STAT, 32'h0002_0010);
    rd_chk("dis_emit", EMIT, emit_m);
    wr(CTRL, 32'd1);
    @(negedge clk);
    chk("fl_pulse", 32'(dat_a_o), 777);
    chk("fl_busy1", 32'(busy_o), 1);
    wr(CTRL, 32'd2);
    chk("fl_dat", 32'(dat_a_o), 0);
    chk("fl_busy0", 32'(busy_o), 0);
    rd_chk("fl_stat", STAT, 0);
    rd_chk("fl_emit", EMIT, emit_m);
    rd_chk("fl_ctrl", CTRL, 0);
    push_desc(1, 14'h1ABC, 100, 0);
    mq.delete();
    wr(CTRL, 32'd1);
    repeat (3) @(negedge clk);
    chk("ar_pulse", 32'(dat_b_o), 32'h1ABC);
    chk("ar_busy1", 32'(busy_o), 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("ar_dat_a", 32'(dat_a_o), 0);
    chk("ar_dat_b", 32'(dat_b_o), 0);
    chk("ar_busy0", 32'(busy_o), 0);
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    rd_chk("ar_ctrl", CTRL, 0);
    rd_chk("ar_desc0", DESC0, 0);
    rd_chk("ar_desc1", DESC1, 0);
    rd_chk("ar_stat", STAT, 0);
    rd_chk("ar_lost", LOST, 0);
    rd_chk("ar_emit", EMIT, 0);
    chk("err", 32'(sys_err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
